stage_mem: RTL and testbench
============================

STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 Parameters SHALL be: DATA_DBUS_WIDTH, default 32, data bus width; ADDR_DBUS_WIDTH, default 32, data address width; ADDR_IBUS_WIDTH, default 32, instruction address width; TIMEOUT_CYCLES, default 16, maximum wait cycles.
REQ-002 i_Clock  in  1  sole clock; all state on rising edge.
REQ-003 i_Reset  in  1  asynchronous, active-high reset.
REQ-004 i_AluOut  in  DATA_DBUS_WIDTH  EX result, used as memory address and as passthrough.
REQ-005 i_WriteData  in  DATA_DBUS_WIDTH  store data.
REQ-006 i_is_zero, i_reg_we, i_mem_we, i_MemToReg, i_is_branch, i_is_jump  in  1 each  EX control; i_MemToReg=1 SHALL mean load.
REQ-007 i_WriteReg  in  5  destination register; i_pc_branch  in  ADDR_IBUS_WIDTH  branch target.
REQ-008 o_MemAddr  out  ADDR_DBUS_WIDTH; o_MemWrData  out  DATA_DBUS_WIDTH; o_MemWe, o_MemRe  out  1; i_MemRdData  in  DATA_DBUS_WIDTH; i_MemReady  in  1: data bus.
REQ-009 o_ReadData, o_AluOut  out  DATA_DBUS_WIDTH; o_reg_we, o_MemToReg  out  1; o_WriteReg  out  5: WB pipeline registers.
REQ-010 o_stall  out  1  freeze upstream; o_pc_src  out  1  take branch; o_pc_branch  out  ADDR_IBUS_WIDTH  target; o_bus_error  out  1  timeout pulse.

Function
REQ-011 Access SHALL be access = i_mem_we | i_MemToReg; i_mem_we and i_MemToReg both 1 SHALL be treated as a store only.
REQ-012 FSM states SHALL be MEM_IDLE and MEM_WAIT.
REQ-013 In MEM_IDLE with access, o_MemWe/o_MemRe SHALL assert combinationally the same cycle, with o_MemAddr = i_AluOut[ADDR_DBUS_WIDTH-1:0] and o_MemWrData = i_WriteData.
REQ-014 MEM_IDLE, access and i_MemReady=1: completes in 0 wait cycles, o_stall=0, WB registers load on that edge.
REQ-015 MEM_IDLE, access and i_MemReady=0: o_stall=1 combinationally; next state MEM_WAIT.
REQ-016 In MEM_WAIT the strobes SHALL stay asserted and o_stall=1 until i_MemReady=1. On that cycle o_stall=0, WB loads, and the next state is MEM_IDLE.
REQ-017 Upstream SHALL hold all inputs stable while o_stall=1; stage_mem SHALL NOT re-latch them.
REQ-018 On any edge with o_stall=1, WB SHALL receive a bubble: o_reg_we<=0, o_MemToReg<=0, other WB registers unchanged.
REQ-019 On a completing or non-access edge: o_ReadData<=i_MemRdData for a load, else 0; o_AluOut<=i_AluOut; o_reg_we, o_MemToReg and o_WriteReg take their inputs.
REQ-020 o_pc_src SHALL equal i_is_jump | (i_is_branch & i_is_zero), combinationally; o_pc_branch=i_pc_branch.
REQ-021 A non-access instruction SHALL never stall; latency to WB is 1 cycle plus wait cycles.

Reset
REQ-022 i_Reset=1 SHALL asynchronously force MEM_IDLE, wait counter 0, all WB registers 0 and o_bus_error 0.
REQ-023 Reset asserted during MEM_WAIT SHALL deassert o_stall, o_MemWe and o_MemRe immediately; no WB write results.

Configuration
REQ-024 With MEM_TIMEOUT_EN defined, a wait counter increments each MEM_WAIT cycle.
REQ-025 If the counter reaches TIMEOUT_CYCLES-1 with i_MemReady=0, the access SHALL abort: next state MEM_IDLE, o_stall=0 that cycle, a bubble to WB, and o_bus_error=1 for exactly one cycle.
REQ-026 Without MEM_TIMEOUT_EN, MEM_WAIT SHALL persist indefinitely, no counter is synthesized, and o_bus_error SHALL be constant 0.

Structure
REQ-027 Enum MemState (MEM_IDLE, MEM_WAIT) SHALL live in package types; TIMEOUT_CYCLES stays a module parameter.
REQ-028 The counter SHALL be sub-module mem_wait_timer, instantiated only under MEM_TIMEOUT_EN; no other sub-modules.

Verification
REQ-029 Load from 0x100 with i_MemReady=1 and i_MemRdData=0xDEADBEEF: next edge o_ReadData=0xDEADBEEF, o_reg_we=1, and o_stall is never 1.
REQ-030 Store 0x12345678 to 0x40 with ready 3 cycles late: o_stall=1 for 3 cycles, o_MemWe held high, o_reg_we=0 throughout.
REQ-031 i_is_branch=1, i_is_zero=1, i_pc_branch=0x200: o_pc_src=1 and o_pc_branch=0x200 the same cycle. With i_is_zero=0: o_pc_src=0.
REQ-032 i_Reset pulsed in the 2nd cycle of MEM_WAIT: o_stall, o_MemWe and o_MemRe drop before the next edge; all WB outputs 0.
REQ-033 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, a load with i_MemReady tied 0: o_bus_error=1 for one cycle, then o_stall=0 and o_reg_we=0.

Source files
------------

// File: rtl/stage_mem_pkg.sv
// -----------------------------------------------------------------------------
// Package: types
// Purpose: Shared definitions for the memory pipeline stage (stage_mem).
//          Holds the MEM-stage FSM state encoding and a small helper for the
//          branch/jump decision, so the top and any checker bound to it agree
//          on the same encoding.
// Contents:
//   MemState     - MEM_IDLE / MEM_WAIT FSM states
//   mem_pc_src() - redirect decision: jump, or branch with zero flag set
// -----------------------------------------------------------------------------
package types;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } MemState;

    function automatic logic mem_pc_src(input logic is_jump,
                                        input logic is_branch,
                                        input logic is_zero);
        return is_jump | (is_branch & is_zero);
    endfunction

endpackage

// File: rtl/stage_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// Module: mem_wait_timer
// Purpose: Wait-cycle counter for stage_mem. Counts consecutive cycles spent
//          in MEM_WAIT and flags the cycle on which the count reaches
//          TIMEOUT_CYCLES-1. Only instantiated when MEM_TIMEOUT_EN is defined.
// Ports:
//   i_Clock    - clock, rising edge
//   i_Reset    - asynchronous active-high reset, clears the count
//   i_count_en - high while the stage sits in MEM_WAIT
//   o_expired  - high during the MEM_WAIT cycle whose count is TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count restarts from zero every time the stage leaves MEM_WAIT, so
    // each new wait episode gets its own full budget.
    always_comb begin
        cnt_d = '0;
        if (i_count_en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = i_count_en & (cnt_q == LAST);

endmodule

// File: rtl/stage_mem.sv
// -----------------------------------------------------------------------------
// Module: stage_mem
// Purpose: MEM pipeline stage. Issues the data-bus access for loads/stores,
//          stalls upstream while the bus is not ready, loads the MEM/WB
//          pipeline registers on completion (bubbles while stalled), and
//          resolves the branch/jump redirect combinationally.
// Configuration:
//   MEM_TIMEOUT_EN - when defined, a mem_wait_timer aborts a bus access after
//                    TIMEOUT_CYCLES wait cycles and pulses o_bus_error for one
//                    cycle. When undefined, MEM_WAIT lasts until i_MemReady,
//                    no counter exists and o_bus_error is tied 0.
// Ports:
//   i_Clock, i_Reset          - clock (rising edge), async active-high reset
//   i_AluOut, i_WriteData     - EX result (address/passthrough), store data
//   i_is_zero, i_reg_we, i_mem_we, i_MemToReg, i_is_branch, i_is_jump
//                             - EX control; i_MemToReg=1 means load
//   i_WriteReg, i_pc_branch   - destination register, branch target
//   o_MemAddr, o_MemWrData, o_MemWe, o_MemRe, i_MemRdData, i_MemReady
//                             - data bus
//   o_ReadData, o_AluOut, o_reg_we, o_MemToReg, o_WriteReg
//                             - MEM/WB pipeline registers
//   o_stall, o_pc_src, o_pc_branch, o_bus_error
//                             - upstream freeze, redirect, timeout pulse
//   o_dbg_state               - current FSM state (MemState encoding)
//
// Handshake: an access is presented with a strobe (o_MemWe/o_MemRe) and
// completes on the rising edge where i_MemReady=1 while the strobe is high.
// While o_stall=1 upstream holds every input steady, so the stage reads the
// access straight from its inputs and never re-latches them.
// -----------------------------------------------------------------------------
module stage_mem
    import types::*;
#(
    parameter int DATA_DBUS_WIDTH = 32,
    parameter int ADDR_DBUS_WIDTH = 32,
    parameter int ADDR_IBUS_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic [DATA_DBUS_WIDTH-1:0] i_AluOut,
    input  logic [DATA_DBUS_WIDTH-1:0] i_WriteData,
    input  logic                       i_is_zero,
    input  logic                       i_reg_we,
    input  logic                       i_mem_we,
    input  logic                       i_MemToReg,
    input  logic                       i_is_branch,
    input  logic                       i_is_jump,
    input  logic [4:0]                 i_WriteReg,
    input  logic [ADDR_IBUS_WIDTH-1:0] i_pc_branch,
    output logic [ADDR_DBUS_WIDTH-1:0] o_MemAddr,
    output logic [DATA_DBUS_WIDTH-1:0] o_MemWrData,
    output logic                       o_MemWe,
    output logic                       o_MemRe,
    input  logic [DATA_DBUS_WIDTH-1:0] i_MemRdData,
    input  logic                       i_MemReady,
    output logic [DATA_DBUS_WIDTH-1:0] o_ReadData,
    output logic [DATA_DBUS_WIDTH-1:0] o_AluOut,
    output logic                       o_reg_we,
    output logic                       o_MemToReg,
    output logic [4:0]                 o_WriteReg,
    output logic                       o_stall,
    output logic                       o_pc_src,
    output logic [ADDR_IBUS_WIDTH-1:0] o_pc_branch,
    output logic                       o_bus_error,
    output logic                       o_dbg_state
);

    MemState state_q;
    MemState state_d;

    logic access;
    logic is_load;
    logic abort;
    logic wb_load;

    logic [DATA_DBUS_WIDTH-1:0] read_data_q;
    logic [DATA_DBUS_WIDTH-1:0] alu_out_q;
    logic                       reg_we_q;
    logic                       mem_to_reg_q;
    logic [4:0]                 write_reg_q;

    // A store with i_MemToReg also set is a store only; it must not read.
    assign access  = i_mem_we | i_MemToReg;
    assign is_load = i_MemToReg & ~i_mem_we;

    // ------------------------------------------------------------------
    // Optional wait timeout
    // ------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    logic timer_expired;
    logic bus_error_q;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_count_en(state_q == MEM_WAIT),
        .o_expired (timer_expired)
    );

    assign abort = (state_q == MEM_WAIT) & access & ~i_MemReady & timer_expired;

    // Registered so the error is a clean single-cycle pulse after the abort edge.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            bus_error_q <= 1'b0;
        end else begin
            bus_error_q <= abort;
        end
    end

    assign o_bus_error = bus_error_q;
`else
    assign abort       = 1'b0;
    assign o_bus_error = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // Reset gates the strobes and stall combinationally so an access that is
    // waiting on the bus is dropped the moment reset rises, not at the edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        o_MemWe = 1'b0;
        o_MemRe = 1'b0;
        o_stall = 1'b0;

        unique case (state_q)
            MEM_IDLE: begin
                if (access) begin
                    o_MemWe = i_mem_we;
                    o_MemRe = is_load;
                    if (!i_MemReady) begin
                        o_stall = 1'b1;
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                o_MemWe = i_mem_we;
                o_MemRe = is_load;
                if (!access || i_MemReady || abort) begin
                    state_d = MEM_IDLE;
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase

        if (i_Reset) begin
            o_MemWe = 1'b0;
            o_MemRe = 1'b0;
            o_stall = 1'b0;
        end
    end

    assign o_MemAddr   = ADDR_DBUS_WIDTH'(i_AluOut);
    assign o_MemWrData = i_WriteData;
    assign o_dbg_state = state_q;

    // ------------------------------------------------------------------
    // MEM/WB pipeline registers
    // A stalled or aborted edge sends a bubble: only the write enables are
    // cleared, the data fields keep their previous contents.
    // ------------------------------------------------------------------
    assign wb_load = ~o_stall & ~abort;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            read_data_q  <= '0;
            alu_out_q    <= '0;
            reg_we_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
            write_reg_q  <= '0;
        end else if (wb_load) begin
            read_data_q  <= is_load ? i_MemRdData : '0;
            alu_out_q    <= i_AluOut;
            reg_we_q     <= i_reg_we;
            mem_to_reg_q <= i_MemToReg;
            write_reg_q  <= i_WriteReg;
        end else begin
            reg_we_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end
    end

    assign o_ReadData = read_data_q;
    assign o_AluOut   = alu_out_q;
    assign o_reg_we   = reg_we_q;
    assign o_MemToReg = mem_to_reg_q;
    assign o_WriteReg = write_reg_q;

    // ------------------------------------------------------------------
    // Branch / jump redirect
    // ------------------------------------------------------------------
    assign o_pc_src    = mem_pc_src(i_is_jump, i_is_branch, i_is_zero);
    assign o_pc_branch = i_pc_branch;

endmodule

// File: tb/tb_stage_mem.sv
// -----------------------------------------------------------------------------
// Testbench: tb_stage_mem
// Directed vectors against stage_mem with hand-computed expectations.
// Inputs change on the falling edge; combinational outputs are checked 1 ns
// later, registered outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_stage_mem;

    // ---------------- clock / reset ----------------
    logic        i_Clock = 1'b0;
    logic        i_Reset;

    always #5 i_Clock = ~i_Clock;

    logic [31:0] i_AluOut, i_WriteData, i_pc_branch, i_MemRdData;
    logic        i_is_zero, i_reg_we, i_mem_we, i_MemToReg, i_is_branch, i_is_jump;
    logic [4:0]  i_WriteReg;
    logic        i_MemReady;
    logic [31:0] o_MemAddr, o_MemWrData, o_ReadData, o_AluOut, o_pc_branch;
    logic        o_MemWe, o_MemRe, o_reg_we, o_MemToReg, o_stall, o_pc_src, o_bus_error;
    logic [4:0]  o_WriteReg;
    logic        o_dbg_state;

    stage_mem #(
        .DATA_DBUS_WIDTH(32),
        .ADDR_DBUS_WIDTH(32),
        .ADDR_IBUS_WIDTH(32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_AluOut   (i_AluOut),
        .i_WriteData(i_WriteData),
        .i_is_zero  (i_is_zero),
        .i_reg_we   (i_reg_we),
        .i_mem_we   (i_mem_we),
        .i_MemToReg (i_MemToReg),
        .i_is_branch(i_is_branch),
        .i_is_jump  (i_is_jump),
        .i_WriteReg (i_WriteReg),
        .i_pc_branch(i_pc_branch),
        .o_MemAddr  (o_MemAddr),
        .o_MemWrData(o_MemWrData),
        .o_MemWe    (o_MemWe),
        .o_MemRe    (o_MemRe),
        .i_MemRdData(i_MemRdData),
        .i_MemReady (i_MemReady),
        .o_ReadData (o_ReadData),
        .o_AluOut   (o_AluOut),
        .o_reg_we   (o_reg_we),
        .o_MemToReg (o_MemToReg),
        .o_WriteReg (o_WriteReg),
        .o_stall    (o_stall),
        .o_pc_src   (o_pc_src),
        .o_pc_branch(o_pc_branch),
        .o_bus_error(o_bus_error),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    int stall_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_nop();
        i_AluOut    = 32'h0;
        i_WriteData = 32'h0;
        i_is_zero   = 1'b0;
        i_reg_we    = 1'b0;
        i_mem_we    = 1'b0;
        i_MemToReg  = 1'b0;
        i_is_branch = 1'b0;
        i_is_jump   = 1'b0;
        i_WriteReg  = 5'd0;
        i_pc_branch = 32'h0;
        i_MemRdData = 32'h0;
        i_MemReady  = 1'b0;
    endtask

    task automatic drive_mem(input logic we, input logic m2r, input logic rwe,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] wreg, input logic [31:0] rdata,
                             input logic ready);
        drive_nop();
        i_mem_we    = we;
        i_MemToReg  = m2r;
        i_reg_we    = rwe;
        i_AluOut    = addr;
        i_WriteData = wdata;
        i_WriteReg  = wreg;
        i_MemRdData = rdata;
        i_MemReady  = ready;
    endtask

    task automatic to_drive_point();
        @(negedge i_Clock);
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        i_Reset = 1'b1;
        drive_nop();
        repeat (2) @(posedge i_Clock);
        #1;
        check("rst_reg_we",   {31'b0, o_reg_we},    32'h0);
        check("rst_alu",      o_AluOut,             32'h0);
        check("rst_rdata",    o_ReadData,           32'h0);
        check("rst_stall",    {31'b0, o_stall},     32'h0);
        check("rst_buserr",   {31'b0, o_bus_error}, 32'h0);
        to_drive_point();
        i_Reset = 1'b0;

        // Branch/jump redirect
        drive_nop();
        i_is_branch = 1'b1; i_is_zero = 1'b1; i_pc_branch = 32'h200;
        #1;
        check("br_taken_src", {31'b0, o_pc_src}, 32'h1);
        check("br_target",    o_pc_branch,       32'h200);
        check("br_no_stall",  {31'b0, o_stall},  32'h0);
        i_is_zero = 1'b0;
        #1;
        check("br_not_taken", {31'b0, o_pc_src}, 32'h0);
        i_is_branch = 1'b0; i_is_jump = 1'b1;
        #1;
        check("jump_src",     {31'b0, o_pc_src}, 32'h1);

        // Non-access ALU op
        to_drive_point();
        drive_nop();
        i_AluOut = 32'h0000A5A5; i_reg_we = 1'b1; i_WriteReg = 5'd7;
        #1;
        check("alu_no_strobe", {30'b0, o_MemWe, o_MemRe}, 32'h0);
        tick();
        check("alu_wb_alu",   o_AluOut,              32'h0000A5A5);
        check("alu_wb_we",    {31'b0, o_reg_we},     32'h1);
        check("alu_wb_wreg",  {27'b0, o_WriteReg},   32'd7);
        check("alu_wb_rdata", o_ReadData,            32'h0);

        // Load, zero wait states
        to_drive_point();
        drive_mem(1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd3, 32'hDEADBEEF, 1'b1);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        check("ld0_re",    {31'b0, o_MemRe},  32'h1);
        check("ld0_we",    {31'b0, o_MemWe},  32'h0);
        check("ld0_addr",  o_MemAddr,         32'h100);
        check("ld0_stall", {31'b0, o_stall},  32'h0);
        tick();
        exp_v = exp_q.pop_front();
        check("ld0_rdata", o_ReadData,          exp_v);
        check("ld0_rwe",   {31'b0, o_reg_we},   32'h1);
        check("ld0_m2r",   {31'b0, o_MemToReg}, 32'h1);
        check("ld0_wreg",  {27'b0, o_WriteReg}, 32'd3);

        // Store, ready three cycles late
        stall_cycles = 0;
        for (int k = 0; k < 3; k++) begin
            to_drive_point();
            drive_mem(1'b1, 1'b0, 1'b0, 32'h40, 32'h12345678, 5'd0, 32'hFFFFFFFF, 1'b0);
            #1;
            if (o_stall === 1'b1) stall_cycles++;
            check("st_we_held", {31'b0, o_MemWe}, 32'h1);
            check("st_re_low",  {31'b0, o_MemRe}, 32'h0);
            check("st_wdata",   o_MemWrData,      32'h12345678);
            check("st_addr",    o_MemAddr,        32'h40);
            tick();
            check("st_bubble_we", {31'b0, o_reg_we}, 32'h0);
            check("st_alu_kept",  o_AluOut,          32'h100);
            check("st_state",     {31'b0, o_dbg_state}, 32'h1);
        end
        check("st_stall_cnt", stall_cycles, 32'd3);
        to_drive_point();
        i_MemReady = 1'b1;
        #1;
        check("st_done_stall", {31'b0, o_stall}, 32'h0);
        check("st_done_we",    {31'b0, o_MemWe}, 32'h1);
        tick();
        check("st_wb_alu",   o_AluOut,            32'h40);
        check("st_wb_rdata", o_ReadData,          32'h0);
        check("st_wb_rwe",   {31'b0, o_reg_we},   32'h0);
        check("st_idle",     {31'b0, o_dbg_state}, 32'h0);

        // Load with one wait state: the stalled edge must bubble i_reg_we
        to_drive_point();
        drive_mem(1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 5'd9, 32'h0BADF00D, 1'b0);
        exp_q.push_back(32'h0BADF00D);
        #1;
        check("ld1_stall", {31'b0, o_stall}, 32'h1);
        tick();
        check("ld1_bubble_we",  {31'b0, o_reg_we},   32'h0);
        check("ld1_bubble_m2r", {31'b0, o_MemToReg}, 32'h0);
        check("ld1_rdata_kept", o_ReadData,          32'h0);
        to_drive_point();
        i_MemReady = 1'b1;
        tick();
        exp_v = exp_q.pop_front();
        check("ld1_rdata", o_ReadData,          exp_v);
        check("ld1_rwe",   {31'b0, o_reg_we},   32'h1);
        check("ld1_wreg",  {27'b0, o_WriteReg}, 32'd9);

        // Store and load flags both set: store only
        to_drive_point();
        drive_mem(1'b1, 1'b1, 1'b0, 32'h44, 32'h55AA55AA, 5'd0, 32'hCAFEF00D, 1'b1);
        #1;
        check("both_we", {31'b0, o_MemWe}, 32'h1);
        check("both_re", {31'b0, o_MemRe}, 32'h0);
        tick();
        check("both_rdata", o_ReadData, 32'h0);

        // Reset in the 2nd MEM_WAIT cycle
        to_drive_point();
        drive_mem(1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd12, 32'h11111111, 1'b0);
        tick();                      // IDLE -> WAIT
        to_drive_point();
        tick();                      // 1st WAIT cycle ends
        to_drive_point();            // inside 2nd WAIT cycle
        check("rw_pre_stall", {31'b0, o_stall}, 32'h1);
        i_Reset = 1'b1;
        #1;
        check("rw_stall", {31'b0, o_stall}, 32'h0);
        check("rw_re",    {31'b0, o_MemRe}, 32'h0);
        check("rw_we",    {31'b0, o_MemWe}, 32'h0);
        check("rw_alu",   o_AluOut,          32'h0);
        check("rw_rdata", o_ReadData,        32'h0);
        check("rw_wreg",  {27'b0, o_WriteReg}, 32'd0);
        tick();
        check("rw_rwe",   {31'b0, o_reg_we},    32'h0);
        check("rw_state", {31'b0, o_dbg_state}, 32'h0);
        to_drive_point();
        i_Reset = 1'b0;
        drive_nop();
        tick();

`ifdef MEM_TIMEOUT_EN
        // Timeout with TIMEOUT_CYCLES=4: 4 stalled cycles, then abort
        stall_cycles = 0;
        to_drive_point();
        drive_mem(1'b0, 1'b1, 1'b1, 32'h500, 32'h0, 5'd5, 32'h77777777, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            if (o_stall === 1'b1) stall_cycles++;
            tick();
            to_drive_point();
        end
        check("to_stall_cnt", stall_cycles, 32'd4);
        #1;
        check("to_abort_stall", {31'b0, o_stall}, 32'h0);
        tick();
        check("to_buserr", {31'b0, o_bus_error}, 32'h1);
        check("to_rwe",    {31'b0, o_reg_we},    32'h0);
        to_drive_point();
        drive_nop();
        #1;
        check("to_after_stall", {31'b0, o_stall}, 32'h0);
        tick();
        check("to_buserr_pulse", {31'b0, o_bus_error}, 32'h0);
`else
        // Without the timeout, a long wait keeps stalling and never errors
        stall_cycles = 0;
        to_drive_point();
        drive_mem(1'b0, 1'b1, 1'b1, 32'h600, 32'h0, 5'd6, 32'h13572468, 1'b0);
        exp_q.push_back(32'h13572468);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (o_stall === 1'b1) stall_cycles++;
            tick();
            to_drive_point();
        end
        check("lw_stall_cnt", stall_cycles, 32'd20);
        check("lw_buserr",    {31'b0, o_bus_error}, 32'h0);
        check("lw_rwe",       {31'b0, o_reg_we},    32'h0);
        i_MemReady = 1'b1;
        tick();
        exp_v = exp_q.pop_front();
        check("lw_rdata", o_ReadData,        exp_v);
        check("lw_rwe_done", {31'b0, o_reg_we}, 32'h1);
`endif

        to_drive_point();
        drive_nop();
        tick();

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
